// File: rtl/fixed_point_multiplication.sv
// fixed_point_multiplication
//   Sequential shift-add multiplier for unsigned Q6.4 operands. The full
//   20-bit product is formed over 10 iterations, one per clock. The result
//   is returned as Q6.4, truncated, with an overflow flag.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-low reset
//   ld_a   load A into the multiplicand register (IDLE only)
//   ld_b   load B into the multiplier register (IDLE only)
//   A, B   Q6.4 operands
//   start  begin a multiply using the registered operands (IDLE only)
//   P      Q6.4 product, prod[13:4], registered
//   ov     integer part of the product exceeds 6 bits, registered
//   busy   high while a multiply is in CALC or DONE
//   done   one-cycle pulse; P and ov are valid from this cycle on
module fixed_point_multiplication (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_a,
  input  logic       ld_b,
  input  logic [9:0] A,
  input  logic [9:0] B,
  input  logic       start,
  output logic [9:0] P,
  output logic       ov,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [9:0]  a_reg;
  logic [9:0]  b_reg;
  logic [10:0] acc;
  logic [9:0]  mq;
  logic [3:0]  cnt;

  logic [10:0] sum;
  logic [20:0] shifted;
  logic [19:0] prod;

  // One iteration: conditionally add the multiplicand into the upper half,
  // then shift {carry, sum, mq} right so the product's low bits move into mq
  // while the consumed multiplier bit drops out.
  always_comb begin
    sum     = mq[0] ? ({1'b0, acc[9:0]} + {1'b0, a_reg}) : acc;
    shifted = {1'b0, sum, mq[9:1]};
    prod    = {acc[9:0], mq};
  end

  // busy decodes the state register only, so it carries no input-to-output path.
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
      P     <= '0;
      ov    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_a) a_reg <= A;
          if (ld_b) b_reg <= B;
          // mq takes the pre-edge b_reg, so a same-edge ld_b lands on the
          // next multiply instead of this one.
          if (start) begin
            acc   <= '0;
            mq    <= b_reg;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= shifted[20:10];
          mq  <= shifted[9:0];
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) state <= DONE;
        end
        DONE: begin
          P     <= prod[13:4];
          ov    <= |prod[19:14];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_multiplication.sv
// Directed testbench for fixed_point_multiplication.
module tb_fixed_point_multiplication;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld_a = 1'b0;
  logic       ld_b = 1'b0;
  logic [9:0] A = '0;
  logic [9:0] B = '0;
  logic       start = 1'b0;
  logic [9:0] P;
  logic       ov;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  fixed_point_multiplication dut (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .A(A), .B(B),
    .start(start), .P(P), .ov(ov), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count edges (starting at n) until done is seen, with a hard bound.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [9:0] b);
    ld_a = 1'b1; ld_b = 1'b1; A = a; B = b;
    tick();
    ld_a = 1'b0; ld_b = 1'b0;
  endtask

  // Start at E0, expect done exactly 11 edges later with the given result.
  task automatic run_mul(input string tag, input logic [9:0] exp_p, input logic exp_ov);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(0, n);
    chk({tag, "_lat"}, n, 11);
    chk({tag, "_P"}, P, exp_p);
    chk({tag, "_ov"}, ov, exp_ov);
    tick();
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int n, seen;

    // Reset state
    tick(); tick();
    chk("rst_P", P, 0);
    chk("rst_ov", ov, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    tick();

    // 3.5 * 2.25 = 7.875
    load(10'h038, 10'h024);
    run_mul("basic", 10'h07E, 1'b0);

    // 63.9375 * 2.0 = 32736 raw -> P=0x3FE, overflow
    load(10'h3FF, 10'h020);
    run_mul("ovf", 10'h3FE, 1'b1);

    // Smallest nonzero product truncates to 0
    load(10'h001, 10'h001);
    run_mul("trunc", 10'h000, 1'b0);

    // Zero multiplicand, normal latency
    load(10'h000, 10'h3FF);
    run_mul("zero", 10'h000, 1'b0);

    // Inputs while busy are ignored; P holds across an accepted start
    load(10'h3FF, 10'h020);
    run_mul("pre", 10'h3FE, 1'b1);
    load(10'h038, 10'h024);
    start = 1'b1;
    tick();                 // E0
    start = 1'b0;
    chk("hold_P", P, 10'h3FE);
    chk("hold_ov", ov, 1);
    tick(); tick();         // E1, E2
    start = 1'b1; ld_a = 1'b1; A = 10'h3FF;
    tick();                 // E3
    start = 1'b0; ld_a = 1'b0;
    wait_done(3, n);
    chk("busy_lat", n, 11);
    chk("busy_P", P, 10'h07E);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) seen++;
    end
    chk("busy_single", seen, 0);
    // a_reg must still hold 0x038; a same-edge ld_b must not affect this run
    ld_b = 1'b1; B = 10'h3FF; start = 1'b1;
    tick();
    ld_b = 1'b0; start = 1'b0;
    wait_done(0, n);
    chk("areg_lat", n, 11);
    chk("areg_P", P, 10'h07E);
    tick();

    // Reset mid-operation
    load(10'h038, 10'h024);
    start = 1'b1;
    tick();                 // E0
    start = 1'b0;
    tick(); tick(); tick(); tick();  // E1..E4
    rst = 1'b0;
    tick();                 // E5
    chk("mrst_busy", busy, 0);
    chk("mrst_P", P, 0);
    chk("mrst_ov", ov, 0);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) seen++;
      tick();
    end
    chk("mrst_nodone", seen, 0);
    load(10'h038, 10'h024);
    run_mul("post", 10'h07E, 1'b0);

    // Back-to-back with start held high: 1.0 * 1.0
    load(10'h010, 10'h010);
    start = 1'b1;
    tick();                 // E0
    wait_done(0, n);
    chk("b2b_lat0", n, 11);
    chk("b2b_P0", P, 10'h010);
    tick();
    wait_done(1, n);
    chk("b2b_gap1", n, 12);
    chk("b2b_P1", P, 10'h010);
    chk("b2b_ov1", ov, 0);
    tick();
    wait_done(1, n);
    chk("b2b_gap2", n, 12);
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("b2b_end", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fixed_point_multiplication.md
# fixed_point_multiplication

Sequential shift-add multiplier for unsigned Q6.4 fixed-point operands (6 integer bits, 4 fraction bits, 10 bits total). It is the inverse operator to the team's `fixed_point_division` datapath, with the same operand format, the same load-register front end, and the same iterate-under-counter style. It forms the full 20-bit product over 10 iterations, then returns a 10-bit Q6.4 result with an overflow flag.

## Interface
Parameters: none. Width is fixed at 10 bits and fraction at 4 bits.

- clk  in  1  rising-edge clock; only clock in the block
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- ld_a  in  1  loads A into operand register a_reg (multiplicand); honoured only in IDLE
- ld_b  in  1  loads B into operand register b_reg (multiplier); honoured only in IDLE
- A  in  10  multiplicand, unsigned Q6.4
- B  in  10  multiplier, unsigned Q6.4
- start  in  1  begins a multiply; honoured only in IDLE
- P  out  10  product, Q6.4, registered; prod[13:4], truncated, not rounded
- ov  out  1  registered; 1 when prod[19:14] != 0 (integer part exceeds 6 bits)
- busy  out  1  high in CALC and DONE
- done  out  1  registered one-cycle pulse; P and ov are valid from this cycle on

## Operation
- Registers:
  - a_reg, b_reg: 10 bits each.
  - acc: 11 bits, including carry.
  - mq: 10 bits; shifts out the multiplier and shifts in product low bits.
  - cnt: 4 bits.
  - state.
  - P, ov, done.
- States are IDLE, CALC and DONE.
- **IDLE:**
  - ld_a and ld_b write the operand registers independently.
  - On start: acc←0, mq←b_reg, cnt←0, state←CALC.
  - The operand register values from before the edge are used. A same-edge ld_b does not affect this multiply.
- **CALC:** each edge performs one iteration.
  - If mq[0], then sum = {1'b0, acc[9:0]} + {1'b0, a_reg}; otherwise sum = acc.
  - Then {acc, mq} ← {1'b0, sum, mq} >> 1, which is 21 bits shifted right by 1.
  - cnt←cnt+1.
  - The edge on which cnt==9 performs the 10th iteration and sets state←DONE.
- **DONE:**
  - prod = {acc[9:0], mq}, 20 bits.
  - On the next edge: P←prod[13:4], ov←|prod[19:14], done←1, state←IDLE.
- done is cleared on every edge where it is not being set. It is never high for more than one cycle.
- Arithmetic:
  - Unsigned throughout.
  - The exact product fits in 20 bits, so acc never loses a carry.
  - Fraction bits prod[3:0] are discarded.
- Boundary conditions:
  - start, ld_a and ld_b while busy are ignored. There is no restart and no operand change.
  - A zero operand is legal. It gives P=0 and ov=0 with normal latency. There is no special early exit.
  - P and ov hold their last values until the next done. They are not cleared when a new start is accepted.
  - start held high continuously produces back-to-back multiplies, one accepted per IDLE cycle.

## Timing
- Reset (rst==0 at an edge):
  - state←IDLE.
  - a_reg, b_reg, acc, mq, cnt ← 0.
  - P←0, ov←0, done←0, busy←0.
- Reset overrides every other input, including mid-CALC and in DONE. An aborted multiply produces no done pulse.
- Latency: start sampled at edge E0.
  - Iterations occur on edges E1..E10.
  - done, P and ov update at E11, so done is high in the cycle following E11.
  - busy is high from after E0 until after E11.
- Throughput: one result per 12 edges when start is held high (E11 returns to IDLE, E12 accepts the next start).
- Outputs are all registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Basic product:**
  - Stimulus: A=0x038 (3.5), B=0x024 (2.25), start.
  - Required: done exactly 11 edges after the start edge, P=0x07E (7.875), ov=0.
- **Overflow:**
  - Stimulus: A=0x3FF (63.9375), B=0x020 (2.0).
  - Required: prod=32736, P=0x3FE, ov=1.
- **Truncation and zero operand:**
  - A=0x001, B=0x001 → P=0x000, ov=0.
  - A=0x000, B=0x3FF → P=0x000, ov=0, both with normal latency.
- **Ignored inputs while busy:**
  - Stimulus: start at E0 with A=0x038, B=0x024. At E3, pulse start and ld_a with A=0x3FF.
  - Required: single done at E11, P=0x07E. a_reg is still 0x038 afterwards.
- **Reset mid-operation:**
  - Stimulus: start, then rst=0 at E5.
  - Required: busy=0, P=0, ov=0, and no done. A new start after rst=1 completes correctly.
- **Back-to-back:**
  - Stimulus: start held high with A=0x010, B=0x010.
  - Required: done pulses 12 edges apart, each with P=0x010 (1.0×1.0), ov=0.
